// File: rtl/scan_pkg.sv
// scan_pkg: shared definitions for the scan result buffer.
//   - command-bus register offsets relative to the block's base address
//   - status and control bit positions
//   - scan_rec_t, the 64-bit record captured per DAC scan step
package scan_pkg;

  // Register offsets on the 8-bit command bus
  localparam logic [7:0] SCAN_STATUS = 8'd0;
  localparam logic [7:0] SCAN_COUNT  = 8'd1;
  localparam logic [7:0] SCAN_DROPS  = 8'd2;

  // Status register bit positions (offset +0, read)
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 3;

  // Control register bit positions (offset +0, write)
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLEAR = 1;

  // One record per scan step; time sits in the upper word.
  // ("time" is a reserved word, hence time_val.)
  typedef struct packed {
    logic [31:0] time_val;
    logic [31:0] signals;
  } scan_rec_t;

  // Assemble the status byte from the individual flags
  function automatic logic [7:0] pack_status(input logic empty_f, input logic full_f,
                                             input logic ovf_f, input logic und_f);
    logic [7:0] st;
    st               = 8'h00;
    st[ST_EMPTY]     = empty_f;
    st[ST_FULL]      = full_f;
    st[ST_OVERFLOW]  = ovf_f;
    st[ST_UNDERFLOW] = und_f;
    return st;
  endfunction

endpackage

// File: rtl/scan_fifo_mem.sv
// scan_fifo_mem: simple dual-port record store, DEPTH x 64 bits.
//   clock50Mhz  in  : system clock
//   key_restart in  : synchronous active-low reset (read register only)
//   we/waddr/wdata  : write port, written on the rising edge when we=1
//   re/raddr        : read port, rdata registered on the rising edge when re=1
//   rdata       out : registered read data, holds between reads
// The array itself has no reset so it can map onto block RAM. A read and a
// write to the same address in one cycle return the old contents.
module scan_fifo_mem
  import scan_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock50Mhz,
  input  logic          key_restart,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  scan_rec_t     wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output scan_rec_t     rdata
);

  scan_rec_t mem [DEPTH];

  always_ff @(posedge clock50Mhz) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock50Mhz) begin
    if (!key_restart) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/scan_fifo.sv
// scan_fifo: result buffer between the counter stage and the Ethernet read path.
//   clock50Mhz   in  : system clock
//   key_restart  in  : synchronous active-low reset
//   addr/data/write  : command bus (8-bit address, 8-bit write data, strobe)
//   data_out     out : combinational register read-back for the selector
//   step_done    in  : pulse, push {step_time, step_signals}
//   rd_req       in  : pulse, pop one record
//   rd_time/rd_signals/rd_valid out : popped record, valid pulse 1 cycle later
//   empty/full   out : occupancy flags
//   overflow     out : sticky, a record was dropped
// Register map (relative to ADDR_BASE):
//   +0 R status {0000, underflow, overflow, full, empty}
//   +0 W bit0 flush pointers, bit1 clear flags and drop counter
//   +1 R count, +2 R drops
module scan_fifo
  import scan_pkg::*;
#(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] ADDR_BASE = 8'h40
) (
  input  logic        clock50Mhz,
  input  logic        key_restart,
  input  logic [7:0]  addr,
  input  logic [7:0]  data,
  input  logic        write,
  output logic [7:0]  data_out,
  input  logic        step_done,
  input  logic [31:0] step_time,
  input  logic [31:0] step_signals,
  input  logic        rd_req,
  output logic [31:0] rd_time,
  output logic [31:0] rd_signals,
  output logic        rd_valid,
  output logic        empty,
  output logic        full,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic          underflow;
  logic [7:0]    drops;

  logic      ctrl_wr;
  logic      flush;
  logic      clear;
  logic      push;
  logic      pop;
  logic      ovf_ev;
  logic      und_ev;
  scan_rec_t wr_rec;
  scan_rec_t rd_rec;

  // Control bits above CLEAR are reserved
  logic unused_data;
  assign unused_data = ^data[7:2];

  assign ctrl_wr = write && (addr == ADDR_BASE + SCAN_STATUS);
  assign flush   = ctrl_wr && data[CTRL_FLUSH];
  assign clear   = ctrl_wr && data[CTRL_CLEAR];

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // A pop frees a slot in the same cycle, so a push into a full buffer is
  // accepted when a pop accompanies it. Flush suppresses both and also
  // suppresses the overflow/underflow events they would otherwise raise.
  assign pop    = rd_req && !empty && !flush;
  assign push   = step_done && !flush && (!full || pop);
  assign ovf_ev = step_done && !flush && full && !pop;
  assign und_ev = rd_req && !flush && empty;

  assign wr_rec.time_val = step_time;
  assign wr_rec.signals  = step_signals;

  always_ff @(posedge clock50Mhz) begin
    if (!key_restart) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Sticky flags and drop counter; clear wins over a same-cycle event
  always_ff @(posedge clock50Mhz) begin
    if (!key_restart) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drops     <= 8'h00;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      drops     <= 8'h00;
    end else begin
      if (ovf_ev) overflow <= 1'b1;
      if (ovf_ev && drops != 8'hFF) drops <= drops + 8'd1;
      if (und_ev) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clock50Mhz) begin
    if (!key_restart) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
    end
  end

  scan_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock50Mhz  (clock50Mhz),
    .key_restart (key_restart),
    .we          (push),
    .waddr       (wp),
    .wdata       (wr_rec),
    .re          (pop),
    .raddr       (rp),
    .rdata       (rd_rec)
  );

  assign rd_time    = rd_rec.time_val;
  assign rd_signals = rd_rec.signals;

  always_comb begin
    data_out = 8'h00;
    if (addr == ADDR_BASE + SCAN_STATUS) begin
      data_out = pack_status(empty, full, overflow, underflow);
    end else if (addr == ADDR_BASE + SCAN_COUNT) begin
      data_out = 8'(count);
    end else if (addr == ADDR_BASE + SCAN_DROPS) begin
      data_out = drops;
    end
  end

endmodule

// File: tb/tb_scan_fifo.sv
// tb_scan_fifo: self-checking bench for scan_fifo (DEPTH=16, ADDR_BASE=8'h40).
// A reference queue holds stored records; records the bench expects to see
// popped are moved to a scoreboard queue when rd_req is driven and compared
// when rd_valid appears.
module tb_scan_fifo;

  localparam logic [7:0] BASE = 8'h40;
  localparam int         DEP  = 16;

  logic        clock50Mhz = 1'b0;
  logic        key_restart = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  data = 8'h00;
  logic        write = 1'b0;
  logic [7:0]  data_out;
  logic        step_done = 1'b0;
  logic [31:0] step_time = 32'd0;
  logic [31:0] step_signals = 32'd0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_time;
  logic [31:0] rd_signals;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic        overflow;

  always #10 clock50Mhz = ~clock50Mhz;

  scan_fifo #(
    .DEPTH     (DEP),
    .ADDR_BASE (BASE)
  ) dut (
    .clock50Mhz   (clock50Mhz),
    .key_restart  (key_restart),
    .addr         (addr),
    .data         (data),
    .write        (write),
    .data_out     (data_out),
    .step_done    (step_done),
    .step_time    (step_time),
    .step_signals (step_signals),
    .rd_req       (rd_req),
    .rd_time      (rd_time),
    .rd_signals   (rd_signals),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem_q[$];
  logic [63:0] exp_q[$];
  logic        m_ovf = 1'b0;
  logic        m_und = 1'b0;
  logic [7:0]  m_drops = 8'h00;
  logic [31:0] last_t = 32'd0;
  logic [31:0] last_s = 32'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock50Mhz);
    #1;
  endtask

  task automatic rd_reg(input logic [7:0] off, input logic [7:0] exp, input string tag);
    addr = BASE + off;
    #1;
    chk(tag, data_out, exp);
    addr = 8'h00;
  endtask

  task automatic chk_model_regs(input string tag);
    int n;
    n = mem_q.size();
    rd_reg(8'd0, {4'b0, m_und, m_ovf, n == DEP, n == 0}, {tag, "_status"});
    rd_reg(8'd1, 8'(n), {tag, "_count"});
    rd_reg(8'd2, m_drops, {tag, "_drops"});
  endtask

  // One clock of stimulus with reference-model update and output checks
  task automatic cycle(input logic sd, input logic [31:0] t, input logic [31:0] s,
                       input logic rr, input logic wr, input logic [7:0] wd);
    logic flush, clr, pop_ok, push_ok, ovf_ev, und_ev;
    logic [63:0] r;
    int n;
    n       = mem_q.size();
    flush   = wr && wd[0];
    clr     = wr && wd[1];
    pop_ok  = rr && n != 0 && !flush;
    push_ok = sd && !flush && (n != DEP || pop_ok);
    ovf_ev  = sd && !flush && n == DEP && !pop_ok;
    und_ev  = rr && !flush && n == 0;

    addr = wr ? BASE : 8'h00;
    data = wd;
    write = wr;
    step_done = sd;
    step_time = t;
    step_signals = s;
    rd_req = rr;

    if (pop_ok) begin
      r = mem_q.pop_front();
      exp_q.push_back(r);
      last_t = r[63:32];
      last_s = r[31:0];
    end
    if (push_ok) mem_q.push_back({t, s});
    if (flush) mem_q.delete();
    if (clr) begin
      m_ovf = 1'b0;
      m_und = 1'b0;
      m_drops = 8'h00;
    end else begin
      if (ovf_ev) m_ovf = 1'b1;
      if (ovf_ev && m_drops != 8'hFF) m_drops = m_drops + 8'd1;
      if (und_ev) m_und = 1'b1;
    end

    tick();
    step_done = 1'b0;
    rd_req = 1'b0;
    write = 1'b0;
    addr = 8'h00;
    data = 8'h00;

    chk("rd_valid", rd_valid, pop_ok);
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rd", 1, 0);
      end else begin
        r = exp_q.pop_front();
        chk("rd_time", rd_time, r[63:32]);
        chk("rd_signals", rd_signals, r[31:0]);
      end
    end else begin
      chk("hold_time", rd_time, last_t);
      chk("hold_signals", rd_signals, last_s);
    end
    chk("empty", empty, mem_q.size() == 0);
    chk("full", full, mem_q.size() == DEP);
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic push(input logic [31:0] t, input logic [31:0] s);
    cycle(1'b1, t, s, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic pop();
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic bus_wr(input logic [7:0] wd);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, wd);
  endtask

  task automatic do_reset(input int ncyc);
    key_restart = 1'b0;
    repeat (ncyc) tick();
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_time", rd_time, 0);
    chk("rst_rd_signals", rd_signals, 0);
    key_restart = 1'b1;
    mem_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_und = 1'b0;
    m_drops = 8'h00;
    last_t = 32'd0;
    last_s = 32'd0;
  endtask

  initial begin
    // Reset
    do_reset(2);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    rd_reg(8'd0, 8'h01, "rst_status");
    rd_reg(8'd1, 8'h00, "rst_count");
    rd_reg(8'd2, 8'h00, "rst_drops");
    rd_reg(8'd3, 8'h00, "unmapped");

    // Ordering
    push(32'd1, 32'd10);
    chk("empty_after_push", empty, 0);
    push(32'd2, 32'd20);
    push(32'd3, 32'd30);
    rd_reg(8'd1, 8'h03, "order_count3");
    repeat (3) pop();
    rd_reg(8'd1, 8'h00, "order_count0");
    chk("order_last_time", rd_time, 32'd3);
    chk("order_last_signals", rd_signals, 32'd30);

    // Overflow: 18 pushes into 16 slots
    for (int i = 0; i < 18; i++) push(32'd100 + i, 32'd200 + i);
    rd_reg(8'd0, 8'h06, "ovf_status");
    rd_reg(8'd1, 8'd16, "ovf_count");
    rd_reg(8'd2, 8'd2, "ovf_drops");
    for (int i = 0; i < 16; i++) pop();
    chk("ovf_last_time", rd_time, 32'd115);
    rd_reg(8'd0, 8'h05, "ovf_drained_status");
    bus_wr(8'h02);
    rd_reg(8'd0, 8'h01, "clr_status");
    rd_reg(8'd2, 8'h00, "clr_drops");

    // Wrap with simultaneous push and pop at full
    for (int i = 0; i < 16; i++) push(32'd300 + i, 32'd500 + i);
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'd400 + i, 32'd600 + i, 1'b1, 1'b0, 8'h00);
    rd_reg(8'd0, 8'h02, "wrap_status");
    rd_reg(8'd1, 8'd16, "wrap_count");
    for (int i = 0; i < 16; i++) pop();
    chk("wrap_last_time", rd_time, 32'd419);
    chk_model_regs("wrap_end");

    // Underflow
    pop();
    chk("und_hold_time", rd_time, 32'd419);
    rd_reg(8'd0, 8'h09, "und_status");
    // Simultaneous push and pop into empty: push only, underflow again
    cycle(1'b1, 32'd7, 32'd70, 1'b1, 1'b0, 8'h00);
    rd_reg(8'd1, 8'h01, "empty_pushpop_count");
    pop();
    chk("empty_pushpop_data", rd_time, 32'd7);
    bus_wr(8'h02);
    rd_reg(8'd0, 8'h01, "und_clr_status");
    rd_reg(8'd2, 8'h00, "und_clr_drops");

    // Flush race: flush + step_done + rd_req together
    for (int i = 0; i < 5; i++) push(32'd800 + i, 32'd900 + i);
    rd_reg(8'd1, 8'h05, "flush_pre_count");
    cycle(1'b1, 32'hDEAD, 32'hBEEF, 1'b1, 1'b1, 8'h01);
    rd_reg(8'd1, 8'h00, "flush_count");
    rd_reg(8'd2, 8'h00, "flush_drops");
    rd_reg(8'd0, 8'h01, "flush_status");
    push(32'd55, 32'd66);
    pop();
    chk("post_flush_time", rd_time, 32'd55);

    // Clear beats a same-cycle overflow
    for (int i = 0; i < 16; i++) push(32'd1000 + i, 32'd2000 + i);
    cycle(1'b1, 32'd1, 32'd1, 1'b0, 1'b1, 8'h02);
    rd_reg(8'd0, 8'h02, "clr_vs_ovf_status");
    rd_reg(8'd2, 8'h00, "clr_vs_ovf_drops");
    // Flush and clear together
    push(32'd3, 32'd3);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 8'h03);
    chk_model_regs("flush_clr");
    rd_reg(8'd0, 8'h01, "flush_clr_status");

    // Drop counter saturation
    for (int i = 0; i < 16; i++) push(i, i);
    for (int i = 0; i < 260; i++) push(32'hFFFF, 32'hFFFF);
    rd_reg(8'd2, 8'hFF, "drops_sat");

    // Reset mid-operation
    bus_wr(8'h03);
    push(32'd11, 32'd12);
    push(32'd13, 32'd14);
    pop();
    do_reset(1);
    tick();
    rd_reg(8'd0, 8'h01, "midrst_status");
    rd_reg(8'd1, 8'h00, "midrst_count");
    chk("midrst_time", rd_time, 0);
    push(32'd21, 32'd22);
    pop();
    chk("midrst_first_time", rd_time, 32'd21);
    chk("midrst_first_signals", rd_signals, 32'd22);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_fifo.md
# scan_fifo

Result buffer that sits directly downstream of the counter stage and upstream of the Ethernet read path. It captures one 64-bit record (32-bit time, 32-bit signal count) each time the counter finishes a DAC scan step, then hands records to the Ethernet side one per read strobe. Status and control are reachable over the shared 8-bit command bus, and `data_out` feeds the selector.

## Interface
- `DEPTH`, 16, number of records; power of two, ≥ 2
- `ADDR_BASE`, 8'h40, command-bus base address; uses offsets +0, +1 and +2
- `clock50Mhz` in 1: system clock
- `key_restart` in 1: reset, synchronous, active-low
- `addr` in 8: command-bus address
- `data` in 8: command-bus write data
- `write` in 1: command-bus write strobe, one cycle
- `data_out` out 8: command-bus read data, routed to the selector
- `step_done` in 1: one-cycle pulse from the counter when a scan step ends
- `step_time` in 32: elapsed time of the step; valid with `step_done`
- `step_signals` in 32: signal count of the step; valid with `step_done`
- `rd_req` in 1: one-cycle pop strobe from the Ethernet side (cread)
- `rd_time` out 32: popped time field
- `rd_signals` out 32: popped signals field
- `rd_valid` out 1: one-cycle pulse; `rd_time`/`rd_signals` are valid
- `empty`, `full` out 1: occupancy flags
- `overflow` out 1: sticky; a record was dropped

## Operation
- **Storage**
  - Circular buffer with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits and wrapping naturally.
  - `count` is `$clog2(DEPTH)+1` bits, range 0..DEPTH.
  - `empty` = (count==0); `full` = (count==DEPTH).
- **Push**
  - Occurs when `step_done` and not full.
  - Stores {step_time, step_signals} at `wp`; `wp`++.
- **Push while full**
  - Record is discarded.
  - `overflow` is set.
  - `drops` (8-bit) increments and saturates at 255.
- **Pop**
  - Occurs when `rd_req` and not empty.
  - Entry at `rp` is registered onto `rd_time`/`rd_signals`; `rd_valid` = 1 for one cycle; `rp`++.
- **Pop while empty**
  - No pointer change and no `rd_valid`.
  - Sticky `underflow` is set.
  - `rd_*` hold their previous values.
- **Simultaneous push and pop**
  - Not empty (including full): both execute, `count` unchanged, no overflow.
  - Empty: push executes, pop is rejected and `underflow` is set.
- **Register map** (`data_out` is combinational decode of `addr`; 8'h00 outside the map)
  - +0 read status: bit0 empty, bit1 full, bit2 overflow, bit3 underflow, bits7:4 zero.
  - +1 read `count`, zero-extended to 8 bits.
  - +2 read `drops`.
  - +0 write with `data[0]`=1: flush. Pointers and count go to 0; stored data is not cleared.
  - +0 write with `data[1]`=1: clear `overflow`, `underflow` and `drops`.
  - Both bits may be set in the same write.
  - Writes to other offsets are ignored.
- **Flush priority**
  - Flush beats push and pop in the same cycle: a push is lost without a drop count, and a pop produces no `rd_valid`.
- **Flag priority**
  - Clear beats a same-cycle overflow or underflow event: the flags read 0 afterwards.

## Timing
- **Reset values** (`key_restart`=0 at a clock edge)
  - `wp`, `rp`, `count` = 0; `empty`=1; `full`=0; `overflow`=0.
  - Internal `underflow` = 0 and `drops` = 0.
  - `rd_valid`=0; `rd_time`, `rd_signals` = 0.
  - `data_out` follows the decode of these values.
- **Reset mid-operation** discards all records; in-flight pulses are lost.
- **Latencies**
  - Push to flag/count update: 1 cycle (`empty` falls on the edge after `step_done`).
  - `rd_req` to `rd_valid`: 1 cycle; data is stable from that cycle until the next pop.
  - Bus write takes effect on the clock edge where `write`=1; readback is correct from the next cycle.
- **Throughput**
  - Back-to-back `rd_req` on consecutive cycles pops consecutive entries, one per cycle.
  - Same rule for back-to-back `step_done` pushes.
- **Memory read** is synchronous, one cycle, with no bypass. A record pushed in cycle N may be popped from cycle N+1 on.

## Structure
- Package `scan_pkg` holds:
  - Offsets `SCAN_STATUS`=0, `SCAN_COUNT`=1, `SCAN_DROPS`=2.
  - Status bit indices and control bit indices (FLUSH=0, CLEAR=1).
  - Typedef `scan_rec_t` packed {time[31:0], signals[31:0]}.
- Sub-module `scan_fifo_mem`: simple dual-port memory, DEPTH × 64 bits, registered read. It keeps the control logic separate so the memory can map to block RAM.

## Test plan
- **Reset:** hold `key_restart`=0 for 2 cycles, then release → empty=1, full=0, read +0 = 8'h01, read +1 = 0, read +2 = 0.
- **Ordering:** push 3 records (time 1,2,3 / signals 10,20,30), then pop 3 → `rd_valid` pulses return (1,10), (2,20), (3,30) in order; count ends 0.
- **Overflow:** push 18 records into DEPTH=16 → full=1, count=16, overflow=1, drops=2; popping all 16 returns records 0–15 only.
- **Wrap and simultaneous:** fill to 16, then push+pop in the same cycle 20 times → count stays 16, no overflow, popped data in strict order across pointer wrap.
- **Underflow:** `rd_req` while empty → no `rd_valid`, status bit3=1, `rd_*` unchanged. Then write +0 = 8'h02 → status 8'h01, drops 0.
- **Flush race:** count=5; flush write coincides with `step_done` and `rd_req` → count 0, no `rd_valid`, drops unchanged.
